reg_wb_arbiter: RTL and testbench
=================================

# reg_wb_arbiter

Write-back arbiter and register scoreboard for the RV32 core's single register-file write port. Up to NUM_REQ execution units (ALU, load/store, mul/div) present write-back requests. The block grants one per cycle and drives the register file's write port from a registered output stage. It also tracks which architectural registers have an outstanding write, so that issue logic can stall on RAW/WAW hazards.

## Interface
- REG_ADDR_WIDTH, 5: register address width; 2**REG_ADDR_WIDTH registers.
- DATA_WIDTH, 32: write data width.
- NUM_REQ, 3: number of write-back requesters (2..8).

- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NUM_REQ  requester i has a write-back pending.
- req_addr  in  NUM_REQ*REG_ADDR_WIDTH  flattened destination addresses; slice i belongs to requester i.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened write data.
- req_ready  out  NUM_REQ  one-hot grant; the transfer occurs when req_valid[i] and req_ready[i] are both high.
- reserve_valid  in  1  issue stage wants to claim destination reserve_addr.
- reserve_addr  in  REG_ADDR_WIDTH  destination being claimed.
- reserve_ready  out  1  claim accepted this cycle.
- query_rs1, query_rs2  in  REG_ADDR_WIDTH  source addresses to check.
- rs1_busy, rs2_busy  out  1  the queried register has an outstanding write.
- wr_enable  out  1  register-file write enable.
- wr_addr  out  REG_ADDR_WIDTH  register-file write address.
- wr_data  out  DATA_WIDTH  register-file write data.
- busy_mask  out  2**REG_ADDR_WIDTH  scoreboard state, for debug.
- wb_err  out  1  sticky flag: a write-back targeted a register that was not reserved.

## Operation
- **Grant:** combinational from req_valid and the priority state. At most one req_ready bit is high per cycle. req_ready[i] is never high while req_valid[i] is low.
- **Output stage:** on an accepted transfer, the next edge loads wr_enable=(addr!=0), wr_addr and wr_data. With no transfer, the next edge loads wr_enable=0. wr_addr and wr_data hold their previous values when wr_enable is 0.
- **Scoreboard set:** busy bit set on accepted reserve (reserve_valid and reserve_ready).
- **Scoreboard clear:** busy bit cleared on the edge where registered wr_enable=1 for wr_addr, i.e. the same edge the register file commits the data.
- **reserve_ready:** equals reserve_valid and (reserve_addr==0 or busy_mask[reserve_addr]==0). A reserve to an already-busy register stalls (WAW).
  - This holds even if that register is being cleared in the same cycle; the reserve is accepted the following cycle.
  - Reserving x0 is accepted and sets nothing.
- **Hazard query:** rs1_busy = busy_mask[query_rs1]; rs2_busy likewise. Both are combinational, and x0 is never busy.
- **wb_err:** set when an accepted transfer has addr!=0 and busy_mask[addr]==0. The write still proceeds. The flag clears only on reset.
- **busy_mask bit 0:** always 0.

## Timing
- **Reset values:** req_ready=0, reserve_ready=0 (combinational, since inputs are low), wr_enable=0, wr_addr=0, wr_data=0, busy_mask=0, wb_err=0. The priority pointer resets to NUM_REQ-1, so requester 0 wins the first contention.
- **Latency:** a transfer at edge N puts wr_enable high during cycle N..N+1. The register file writes at edge N+1, and the busy bit clears at edge N+1. A read of that register in cycle N+1 returns the new value.
- **Throughput:** one write-back per cycle, sustained.
- **Reset mid-operation:** reset_n low immediately clears every output register and the scoreboard. In-flight writes are discarded.
- **Simultaneous reserve and clear of different registers:** both take effect on the same edge.

## Configuration
- **WB_ROUND_ROBIN_EN defined:** round-robin priority. The search starts at the index after the last granted requester. The pointer updates only on an accepted transfer.
- **WB_ROUND_ROBIN_EN undefined:** fixed priority, where the lowest valid index wins. There is no pointer state.

## Test plan
- **Reset values:** assert reset_n=0 mid-write with busy_mask=0x0000_0004 -> all outputs 0, and busy_mask=0 asynchronously before the next clock.
- **Single write-back:** reserve x5, then req0 writes x5=0xDEADBEEF -> wr_enable high for one cycle with wr_addr=5, busy_mask[5] cleared at the following edge, wb_err=0.
- **Contention:** req0..2 all valid continuously, with the macro defined -> grants are 0,1,2,0. With the macro undefined -> req0 every cycle.
- **WAW stall:** with x7 busy, reserve_valid=1 and reserve_addr=7 -> reserve_ready=0 until the cycle after x7's write-back commits, then 1.
- **x0:** reserve x0, then req1 writes x0=0x1 -> reserve_ready=1, busy_mask unchanged, wr_enable stays 0, wb_err=0.
- **Unreserved write:** req2 writes x9 without a prior reserve -> the write occurs, wb_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus between execution units, issue logic and the register-file write port.
// The arbiter binds the slave modport; requesters, issue and the register file bind master.
interface reg_wb_arbiter_if #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 3
);
  // Handshakes: a transfer happens in a cycle where valid and ready are both high.
  // ready is a combinational function of valid and current state and never depends
  // on the transfer itself; valid may not wait for ready.
  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ*REG_ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data;
  logic [NUM_REQ-1:0]                req_ready;

  logic                      reserve_valid;
  logic [REG_ADDR_WIDTH-1:0] reserve_addr;
  logic                      reserve_ready;

  logic [REG_ADDR_WIDTH-1:0] query_rs1;
  logic [REG_ADDR_WIDTH-1:0] query_rs2;
  logic                      rs1_busy;
  logic                      rs2_busy;

  logic                         wr_enable;
  logic [REG_ADDR_WIDTH-1:0]    wr_addr;
  logic [DATA_WIDTH-1:0]        wr_data;
  logic [2**REG_ADDR_WIDTH-1:0] busy_mask;
  logic                         wb_err;

  modport slave (
    input  req_valid, req_addr, req_data, reserve_valid, reserve_addr, query_rs1, query_rs2,
    output req_ready, reserve_ready, rs1_busy, rs2_busy, wr_enable, wr_addr, wr_data,
           busy_mask, wb_err
  );

  modport master (
    output req_valid, req_addr, req_data, reserve_valid, reserve_addr, query_rs1, query_rs2,
    input  req_ready, reserve_ready, rs1_busy, rs2_busy, wr_enable, wr_addr, wr_data,
           busy_mask, wb_err
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter with registered register-file write port and busy-register scoreboard.
// Define WB_ROUND_ROBIN_EN for round-robin priority; otherwise lowest index wins.
module reg_wb_arbiter #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REQ        = 3
) (
  input logic               clock,
  input logic               reset_n,
  reg_wb_arbiter_if.slave   bus
);
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int NUM_RF = 2**REG_ADDR_WIDTH;

  logic [NUM_REQ-1:0]        grant;
  logic [IDX_W-1:0]          gnt_idx;
  logic                      xfer;
  logic [REG_ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0]     sel_data;

  logic                      wr_enable_q;
  logic [REG_ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0]     wr_data_q;
  logic [NUM_RF-1:0]         busy_q;
  logic [NUM_RF-1:0]         busy_next;
  logic                      wb_err_q;
  logic                      reserve_ok;

`ifdef WB_ROUND_ROBIN_EN
  // Last granted requester; the search begins one past it.
  logic [IDX_W-1:0] rr_ptr;

  always_comb begin
    int cand;
    cand    = 0;
    xfer    = 1'b0;
    gnt_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(rr_ptr) + off) % NUM_REQ;
      if (!xfer && bus.req_valid[cand]) begin
        xfer    = 1'b1;
        gnt_idx = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else if (xfer) begin
      rr_ptr <= gnt_idx;
    end
  end
`else
  always_comb begin
    xfer    = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        xfer    = 1'b1;
        gnt_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    grant    = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer && gnt_idx == IDX_W'(i)) begin
        grant[i] = 1'b1;
        sel_addr = bus.req_addr[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // x0 is never marked busy, so only nonzero destinations need the busy check.
  assign reserve_ok = bus.reserve_valid &&
                      (bus.reserve_addr == '0 || !busy_q[bus.reserve_addr]);

  always_comb begin
    busy_next = busy_q;
    if (wr_enable_q) begin
      busy_next[wr_addr_q] = 1'b0;
    end
    if (reserve_ok) begin
      busy_next[bus.reserve_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_enable_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
      wb_err_q    <= 1'b0;
    end else begin
      busy_q      <= busy_next;
      wr_enable_q <= xfer && (sel_addr != '0);
      // Address/data move only with a real write so they hold while wr_enable is low.
      if (xfer && sel_addr != '0) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
        if (!busy_q[sel_addr]) begin
          wb_err_q <= 1'b1;
        end
      end
    end
  end

  assign bus.req_ready     = grant;
  assign bus.reserve_ready = reserve_ok;
  assign bus.rs1_busy      = busy_q[bus.query_rs1];
  assign bus.rs2_busy      = busy_q[bus.query_rs2];
  assign bus.wr_enable     = wr_enable_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.busy_mask     = busy_q;
  assign bus.wb_err        = wb_err_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: reset, write-back, contention, WAW stall, x0, unreserved write.
module tb_reg_wb_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  reg_wb_arbiter_if #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  reg_wb_arbiter #(.REG_ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clk_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.req_valid[idx]           = 1'b1;
    bus.req_addr[idx*AW +: AW]   = addr;
    bus.req_data[idx*DW +: DW]   = data;
  endtask

  task automatic idle_inputs();
    bus.req_valid     = '0;
    bus.req_addr      = '0;
    bus.req_data      = '0;
    bus.reserve_valid = 1'b0;
    bus.reserve_addr  = '0;
    bus.query_rs1     = '0;
    bus.query_rs2     = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    #3;
    checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL rst_req_ready got=%b exp=000", bus.req_ready); end
    checks++; if (bus.reserve_ready !== 1'b0) begin failures++; $display("FAIL rst_reserve_ready got=%b exp=0", bus.reserve_ready); end
    checks++; if (bus.wr_enable !== 1'b0) begin failures++; $display("FAIL rst_wr_enable got=%b exp=0", bus.wr_enable); end
    checks++; if (bus.wr_addr !== 5'd0) begin failures++; $display("FAIL rst_wr_addr got=%0d exp=0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL rst_wr_data got=%h exp=0", bus.wr_data); end
    checks++; if (bus.busy_mask !== 32'd0) begin failures++; $display("FAIL rst_busy_mask got=%h exp=0", bus.busy_mask); end
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL rst_wb_err got=%b exp=0", bus.wb_err); end
    @(negedge clock);
    reset_n = 1'b1;
    clk_step();
  endtask

  task automatic test_single_wb();
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd5;
    #1;
    checks++; if (bus.reserve_ready !== 1'b1) begin failures++; $display("FAIL wb_reserve_ready got=%b exp=1", bus.reserve_ready); end
    clk_step();
    bus.reserve_valid = 1'b0;
    bus.query_rs1     = 5'd5;
    bus.query_rs2     = 5'd6;
    #1;
    checks++; if (bus.busy_mask !== 32'h0000_0020) begin failures++; $display("FAIL wb_busy_set got=%h exp=00000020", bus.busy_mask); end
    checks++; if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b0) begin failures++; $display("FAIL wb_query got=%b%b exp=10", bus.rs1_busy, bus.rs2_busy); end
    drive_req(0, 5'd5, 32'hDEAD_BEEF);
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL wb_grant got=%b exp=001", bus.req_ready); end
    clk_step();
    bus.req_valid = '0;
    checks++; if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 5'd5 || bus.wr_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wb_write got=%b/%0d/%h exp=1/5/deadbeef", bus.wr_enable, bus.wr_addr, bus.wr_data); end
    checks++; if (bus.busy_mask !== 32'h0000_0020) begin failures++; $display("FAIL wb_busy_held got=%h exp=00000020", bus.busy_mask); end
    clk_step();
    checks++; if (bus.wr_enable !== 1'b0 || bus.busy_mask !== 32'd0 || bus.wb_err !== 1'b0) begin
      failures++; $display("FAIL wb_commit got=%b/%h/%b exp=0/00000000/0", bus.wr_enable, bus.busy_mask, bus.wb_err); end
    checks++; if (bus.wr_addr !== 5'd5 || bus.wr_data !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL wb_hold got=%0d/%h exp=5/deadbeef", bus.wr_addr, bus.wr_data); end
  endtask

  task automatic test_reset_mid();
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd2;
    clk_step();
    bus.reserve_valid = 1'b0;
    drive_req(0, 5'd2, 32'h1234_5678);
    clk_step();
    bus.req_valid = '0;
    checks++; if (bus.wr_enable !== 1'b1 || bus.busy_mask !== 32'h0000_0004) begin
      failures++; $display("FAIL mid_pre got=%b/%h exp=1/00000004", bus.wr_enable, bus.busy_mask); end
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.wr_enable !== 1'b0 || bus.wr_addr !== 5'd0 || bus.wr_data !== 32'd0 ||
                  bus.busy_mask !== 32'd0 || bus.wb_err !== 1'b0 || bus.req_ready !== 3'b000) begin
      failures++; $display("FAIL mid_reset got=%b/%0d/%h/%h/%b exp=0/0/0/0/0",
                           bus.wr_enable, bus.wr_addr, bus.wr_data, bus.busy_mask, bus.wb_err); end
    @(negedge clock);
    reset_n = 1'b1;
    clk_step();
  endtask

  task automatic test_contention();
    logic [NR-1:0] exp_tbl [4];
`ifdef WB_ROUND_ROBIN_EN
    exp_tbl = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
    exp_tbl = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
    drive_req(0, 5'd0, 32'hA0);
    drive_req(1, 5'd0, 32'hA1);
    drive_req(2, 5'd0, 32'hA2);
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.req_ready !== exp_tbl[c]) begin failures++; $display("FAIL contention_%0d got=%b exp=%b", c, bus.req_ready, exp_tbl[c]); end
      clk_step();
    end
    bus.req_valid = '0;
    checks++; if (bus.wr_enable !== 1'b0 || bus.wb_err !== 1'b0) begin
      failures++; $display("FAIL contention_x0 got=%b/%b exp=0/0", bus.wr_enable, bus.wb_err); end
  endtask

  task automatic test_waw();
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd7;
    clk_step();
    #1;
    checks++; if (bus.reserve_ready !== 1'b0) begin failures++; $display("FAIL waw_stall0 got=%b exp=0", bus.reserve_ready); end
    clk_step();
    checks++; if (bus.reserve_ready !== 1'b0) begin failures++; $display("FAIL waw_stall1 got=%b exp=0", bus.reserve_ready); end
    drive_req(1, 5'd7, 32'h77);
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL waw_grant got=%b exp=010", bus.req_ready); end
    clk_step();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.reserve_ready !== 1'b0 || bus.wr_enable !== 1'b1) begin
      failures++; $display("FAIL waw_commit_cycle got=%b/%b exp=0/1", bus.reserve_ready, bus.wr_enable); end
    clk_step();
    checks++; if (bus.reserve_ready !== 1'b1 || bus.busy_mask !== 32'd0) begin
      failures++; $display("FAIL waw_accept got=%b/%h exp=1/00000000", bus.reserve_ready, bus.busy_mask); end
    clk_step();
    bus.reserve_valid = 1'b0;
    checks++; if (bus.busy_mask !== 32'h0000_0080) begin failures++; $display("FAIL waw_reclaim got=%h exp=00000080", bus.busy_mask); end
    // Clear x7 on the same edge that x3 is reserved.
    drive_req(1, 5'd7, 32'h78);
    clk_step();
    bus.req_valid     = '0;
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd3;
    clk_step();
    bus.reserve_valid = 1'b0;
    checks++; if (bus.busy_mask !== 32'h0000_0008) begin failures++; $display("FAIL waw_swap got=%h exp=00000008", bus.busy_mask); end
    drive_req(2, 5'd3, 32'h33);
    clk_step();
    bus.req_valid = '0;
    clk_step();
    checks++; if (bus.busy_mask !== 32'd0 || bus.wb_err !== 1'b0) begin
      failures++; $display("FAIL waw_clean got=%h/%b exp=00000000/0", bus.busy_mask, bus.wb_err); end
  endtask

  task automatic test_x0();
    bus.reserve_valid = 1'b1;
    bus.reserve_addr  = 5'd0;
    bus.query_rs1     = 5'd0;
    #1;
    checks++; if (bus.reserve_ready !== 1'b1) begin failures++; $display("FAIL x0_reserve got=%b exp=1", bus.reserve_ready); end
    clk_step();
    bus.reserve_valid = 1'b0;
    checks++; if (bus.busy_mask !== 32'd0 || bus.rs1_busy !== 1'b0) begin
      failures++; $display("FAIL x0_busy got=%h/%b exp=00000000/0", bus.busy_mask, bus.rs1_busy); end
    drive_req(1, 5'd0, 32'h1);
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL x0_grant got=%b exp=010", bus.req_ready); end
    clk_step();
    bus.req_valid = '0;
    checks++; if (bus.wr_enable !== 1'b0 || bus.busy_mask !== 32'd0 || bus.wb_err !== 1'b0) begin
      failures++; $display("FAIL x0_write got=%b/%h/%b exp=0/00000000/0", bus.wr_enable, bus.busy_mask, bus.wb_err); end
  endtask

  task automatic test_unreserved();
    drive_req(2, 5'd9, 32'h99);
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin failures++; $display("FAIL unres_grant got=%b exp=100", bus.req_ready); end
    clk_step();
    bus.req_valid = '0;
    checks++; if (bus.wr_enable !== 1'b1 || bus.wr_addr !== 5'd9 || bus.wr_data !== 32'h99 || bus.wb_err !== 1'b1) begin
      failures++; $display("FAIL unres_write got=%b/%0d/%h/%b exp=1/9/00000099/1", bus.wr_enable, bus.wr_addr, bus.wr_data, bus.wb_err); end
    for (int c = 0; c < 3; c++) clk_step();
    checks++; if (bus.wb_err !== 1'b1 || bus.busy_mask !== 32'd0) begin
      failures++; $display("FAIL unres_sticky got=%b/%h exp=1/00000000", bus.wb_err, bus.busy_mask); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus.wb_err !== 1'b0) begin failures++; $display("FAIL unres_reset got=%b exp=0", bus.wb_err); end
    @(negedge clock);
    reset_n = 1'b1;
    clk_step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_wb();
    test_reset_mid();
    test_contention();
    test_waw();
    test_x0();
    test_unreserved();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
